// File: rtl/trng_block_packer.sv
// trng_block_packer: packs raw TRNG samples into 128-bit blocks for the AES
// post-processor. Two 128-bit buffers ping-pong so sampling keeps going while
// the downstream block is being consumed; samples that find both buffers full
// are dropped and counted in a saturating counter.
// Optional feature: define TRNG_RCT_EN to enable the repetition-count health
// test (sticky o_alarm, cleared by i_clear_alarm). Without it o_alarm is 0.
module trng_block_packer #(
  parameter int SAMPLE_W   = 1,
  parameter int RCT_CUTOFF = 21,
  parameter int DROP_CNT_W = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_enable,
  input  logic                  i_sample_valid,
  input  logic [SAMPLE_W-1:0]   i_sample,
  input  logic                  i_consumed,
  input  logic                  i_clear_alarm,
  output logic [127:0]          o_dat,
  output logic                  o_valid,
  output logic [DROP_CNT_W-1:0] o_dropped,
  output logic                  o_alarm
);

  localparam int NS    = 128 / SAMPLE_W;
  localparam int CNT_W = (NS > 1) ? $clog2(NS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NS - 1);

  logic [1:0][127:0]     blk_q, blk_d;
  logic [1:0]            full_q, full_d;
  logic                  wr_sel_q, wr_sel_d;
  logic                  rd_sel_q, rd_sel_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DROP_CNT_W-1:0] dropped_q, dropped_d;
  logic                  valid_q, valid_d;
  logic [127:0]          dat_q, dat_d;

  logic samp_req, accept, drop, consume, halt, rct_trip;

`ifdef TRNG_RCT_EN
  localparam int REP_W = $clog2(RCT_CUTOFF + 1);

  logic                alarm_q, alarm_d;
  logic [REP_W-1:0]    rep_q, rep_d, rep_nxt;
  logic [SAMPLE_W-1:0] prev_q, prev_d;
  logic                prev_vld_q, prev_vld_d;

  assign halt    = alarm_q;
  assign o_alarm = alarm_q;
`else
  // No health test: alarm input and cutoff are intentionally unused.
  logic [31:0] unused_cfg;
  assign unused_cfg = {31'(RCT_CUTOFF), i_clear_alarm};
  assign halt       = 1'b0;
  assign o_alarm    = 1'b0;
`endif

  // Full flag is sampled before the edge: a buffer freed this cycle is not writable yet.
  assign samp_req = i_enable & i_sample_valid;
  assign accept   = samp_req & ~full_q[wr_sel_q] & ~halt;
  assign drop     = samp_req & full_q[wr_sel_q];
  assign consume  = i_consumed & valid_q;

  // Next-state: fill, completion, drop count, handshake and health test.
  always_comb begin
    blk_d     = blk_q;
    full_d    = full_q;
    wr_sel_d  = wr_sel_q;
    rd_sel_d  = rd_sel_q;
    cnt_d     = cnt_q;
    dropped_d = dropped_q;
    rct_trip  = 1'b0;
`ifdef TRNG_RCT_EN
    alarm_d    = alarm_q;
    rep_d      = rep_q;
    rep_nxt    = rep_q;
    prev_d     = prev_q;
    prev_vld_d = prev_vld_q;
`endif

    if (accept) begin
      blk_d[wr_sel_q][cnt_q*SAMPLE_W +: SAMPLE_W] = i_sample;
`ifdef TRNG_RCT_EN
      rep_nxt    = (prev_vld_q && (i_sample == prev_q)) ? rep_q + 1'b1 : REP_W'(1);
      rep_d      = rep_nxt;
      prev_d     = i_sample;
      prev_vld_d = 1'b1;
      rct_trip   = (rep_nxt >= REP_W'(RCT_CUTOFF));
      if (rct_trip) alarm_d = 1'b1;
`endif
      // A health-test trip throws away the partial fill instead of completing it.
      if (rct_trip) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
        cnt_d            = '0;
        full_d[wr_sel_q] = 1'b1;
        wr_sel_d         = ~wr_sel_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    if (drop && (dropped_q != {DROP_CNT_W{1'b1}}))
      dropped_d = dropped_q + 1'b1;

    // Completion and consume never touch the same buffer, so both apply.
    if (consume) begin
      full_d[rd_sel_q] = 1'b0;
      rd_sel_d         = ~rd_sel_q;
    end

`ifdef TRNG_RCT_EN
    if (i_clear_alarm) begin
      alarm_d    = 1'b0;
      rep_d      = '0;
      prev_vld_d = 1'b0;
    end
`endif

    // Outputs registered from next state: valid the cycle after the last accept.
    valid_d = full_d[rd_sel_d];
    dat_d   = blk_d[rd_sel_d];
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      blk_q     <= '0;
      full_q    <= '0;
      wr_sel_q  <= 1'b0;
      rd_sel_q  <= 1'b0;
      cnt_q     <= '0;
      dropped_q <= '0;
      valid_q   <= 1'b0;
      dat_q     <= '0;
    end else begin
      blk_q     <= blk_d;
      full_q    <= full_d;
      wr_sel_q  <= wr_sel_d;
      rd_sel_q  <= rd_sel_d;
      cnt_q     <= cnt_d;
      dropped_q <= dropped_d;
      valid_q   <= valid_d;
      dat_q     <= dat_d;
    end
  end

`ifdef TRNG_RCT_EN
  // Health-test state.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      alarm_q    <= 1'b0;
      rep_q      <= '0;
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
    end else begin
      alarm_q    <= alarm_d;
      rep_q      <= rep_d;
      prev_q     <= prev_d;
      prev_vld_q <= prev_vld_d;
    end
  end
`endif

  assign o_valid   = valid_q;
  assign o_dat     = dat_q;
  assign o_dropped = dropped_q;

endmodule

// File: tb/tb_trng_block_packer.sv
// Bench for trng_block_packer: unit 0 is SAMPLE_W=1 (16-bit drop counter),
// unit 1 is SAMPLE_W=8 with a 4-bit drop counter to reach saturation quickly.
// A scoreboard queue holds completed blocks per unit in fill order.
module tb_trng_block_packer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic         en0, v0, c0, ca0;
  logic [0:0]   s0;
  logic [127:0] dat0;
  logic         val0, al0;
  logic [15:0]  drp0;

  logic         en1, v1, c1, ca1;
  logic [7:0]   s1;
  logic [127:0] dat1;
  logic         val1, al1;
  logic [3:0]   drp1;

  trng_block_packer #(.SAMPLE_W(1), .RCT_CUTOFF(21), .DROP_CNT_W(16)) u_dut0 (
    .i_clk(clk), .i_reset_n(rst_n), .i_enable(en0), .i_sample_valid(v0),
    .i_sample(s0), .i_consumed(c0), .i_clear_alarm(ca0),
    .o_dat(dat0), .o_valid(val0), .o_dropped(drp0), .o_alarm(al0));

  trng_block_packer #(.SAMPLE_W(8), .RCT_CUTOFF(21), .DROP_CNT_W(4)) u_dut1 (
    .i_clk(clk), .i_reset_n(rst_n), .i_enable(en1), .i_sample_valid(v1),
    .i_sample(s1), .i_consumed(c1), .i_clear_alarm(ca1),
    .o_dat(dat1), .o_valid(val1), .o_dropped(drp1), .o_alarm(al1));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  typedef struct { int u; logic [127:0] d; } blk_t;
  blk_t sbq[$];

  int           mcnt[2];
  logic [127:0] macc[2];
  int           mdrp[2];
  bit           malarm[2];
  int           mrep[2];
  logic [7:0]   mprev[2];
  bit           mpv[2];

  bit         ten[2], tv[2], tc[2], tca[2];
  logic [7:0] ts[2];

  function automatic int qcnt(int u);
    int n = 0;
    foreach (sbq[i]) if (sbq[i].u == u) n++;
    return n;
  endfunction

  function automatic int qfirst(int u);
    foreach (sbq[i]) if (sbq[i].u == u) return i;
    return -1;
  endfunction

  function automatic void mreset();
    sbq.delete();
    for (int u = 0; u < 2; u++) begin
      mcnt[u] = 0; macc[u] = '0; mdrp[u] = 0; malarm[u] = 0;
      mrep[u] = 0; mprev[u] = '0; mpv[u] = 0;
    end
  endfunction

  function automatic void idle();
    for (int u = 0; u < 2; u++) begin
      ten[u] = 0; tv[u] = 0; tc[u] = 0; tca[u] = 0; ts[u] = '0;
    end
  endfunction

  function automatic void put(int u, logic [7:0] s);
    ten[u] = 1; tv[u] = 1; ts[u] = s;
  endfunction

  // Reference behaviour of one unit for one clock edge; n_before = full buffers before the edge.
  function automatic void model_unit(int u, int n_before);
    int         w    = (u == 0) ? 1 : 8;
    int         ns   = 128 / w;
    int         dmax = (u == 0) ? 65535 : 15;
    int         mask = (1 << w) - 1;
    logic [7:0] smp  = ts[u] & 8'(mask);
    bit         req  = ten[u] && tv[u];
    bit         acc  = req && (n_before < 2) && !malarm[u];
    bit         trip = 0;
    blk_t       b;
    if (tc[u] && n_before > 0) sbq.delete(qfirst(u));
    if (acc) begin
      macc[u] |= 128'(smp) << (mcnt[u] * w);
`ifdef TRNG_RCT_EN
      if (mpv[u] && smp == mprev[u]) mrep[u]++; else mrep[u] = 1;
      mprev[u] = smp; mpv[u] = 1;
      if (mrep[u] >= 21) begin trip = 1; malarm[u] = 1; end
`endif
      if (trip) begin
        mcnt[u] = 0; macc[u] = '0;
      end else if (mcnt[u] == ns - 1) begin
        b.u = u; b.d = macc[u];
        sbq.push_back(b);
        mcnt[u] = 0; macc[u] = '0;
      end else begin
        mcnt[u]++;
      end
    end
    if (req && n_before == 2 && mdrp[u] < dmax) mdrp[u]++;
`ifdef TRNG_RCT_EN
    if (tca[u]) begin malarm[u] = 0; mrep[u] = 0; mpv[u] = 0; end
`endif
  endfunction

  task automatic check_all();
    int n0 = qcnt(0);
    int n1 = qcnt(1);
    chk("valid0", val0, n0 > 0);
    if (n0 > 0) chk("dat0", dat0, sbq[qfirst(0)].d);
    chk("drop0", drp0, mdrp[0]);
    chk("alarm0", al0, malarm[0]);
    chk("valid1", val1, n1 > 0);
    if (n1 > 0) chk("dat1", dat1, sbq[qfirst(1)].d);
    chk("drop1", drp1, mdrp[1]);
    chk("alarm1", al1, malarm[1]);
  endtask

  // One clock: drive from the stimulus arrays, update model at the edge, check 1 ns later.
  task automatic step();
    int n0, n1;
    en0 = ten[0]; v0 = tv[0]; s0 = ts[0][0]; c0 = tc[0]; ca0 = tca[0];
    en1 = ten[1]; v1 = tv[1]; s1 = ts[1];    c1 = tc[1]; ca1 = tca[1];
    @(posedge clk);
    n0 = qcnt(0);
    n1 = qcnt(1);
    model_unit(0, n0);
    model_unit(1, n1);
    #1;
    check_all();
    idle();
  endtask

  task automatic zero_check(input string tag);
    chk({tag, "_val0"}, val0, 1'b0);
    chk({tag, "_dat0"}, dat0, 128'h0);
    chk({tag, "_drp0"}, drp0, 16'h0);
    chk({tag, "_al0"},  al0,  1'b0);
    chk({tag, "_val1"}, val1, 1'b0);
    chk({tag, "_dat1"}, dat1, 128'h0);
    chk({tag, "_drp1"}, drp1, 4'h0);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    zero_check(tag);
    repeat (2) @(posedge clk);
    mreset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [127:0] pat5;
  logic [127:0] pat8;

  initial begin
    pat5 = {32{4'h5}};
    pat8 = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
    idle();
    en0 = 0; v0 = 0; s0 = '0; c0 = 0; ca0 = 0;
    en1 = 0; v1 = 0; s1 = '0; c1 = 0; ca1 = 0;
    mreset();
    rst_n = 1'b1;
    #1;
    do_reset("rst");

    // Alternating bits on unit 0, bytes 0x00..0x0F on unit 1.
    for (int i = 0; i < 128; i++) begin
      put(0, (i % 2 == 0) ? 8'd1 : 8'd0);
      if (i < 16) put(1, 8'(i));
      step();
    end
    chk("alt_val", val0, 1'b1);
    chk("alt_dat", dat0, pat5);
    chk("byte_dat", dat1, pat8);
    tc[0] = 1; tc[1] = 1;
    step();
    chk("byte_cons", val1, 1'b0);
    chk("alt_cons", val0, 1'b0);

    // Block 2 completes in the same cycle block 1 is consumed.
    do_reset("rst2");
    for (int i = 0; i < 256; i++) begin
      put(0, 8'($urandom_range(1)));
      if (i == 255) tc[0] = 1;
      step();
    end
    chk("sim_val", val0, 1'b1);
    chk("sim_drop", drp0, 16'd0);
    tc[0] = 1;
    step();
    chk("sim_empty", val0, 1'b0);

    // Overflow: 300 samples, two blocks held, 44 dropped; then one consume.
    do_reset("rst3");
    for (int i = 0; i < 300; i++) begin
      put(0, 8'($urandom_range(1)));
      step();
    end
    chk("ovf_drop", drp0, 16'd44);
    tc[0] = 1;
    step();
    chk("ovf_val", val0, 1'b1);

    // Partial fill with a block presented, then asynchronous reset.
    for (int i = 0; i < 10; i++) begin
      put(0, 8'($urandom_range(1)));
      step();
    end
    do_reset("amid");
    for (int i = 0; i < 128; i++) begin
      put(0, 8'($urandom_range(1)));
      step();
    end
    chk("fresh_val", val0, 1'b1);

    // Unit 1 drop counter saturation.
    for (int i = 0; i < 60; i++) begin
      put(1, 8'(i + 3));
      step();
    end
    chk("sat_drop", drp1, 4'hF);

    // Repetition-count test: 5 mixed bits then 21 ones.
    do_reset("rst4");
    for (int i = 0; i < 26; i++) begin
      put(0, (i < 5) ? 8'(i % 2) : 8'd1);
      step();
    end
`ifdef TRNG_RCT_EN
    chk("rct_alarm", al0, 1'b1);
`else
    chk("rct_off", al0, 1'b0);
`endif
    for (int i = 0; i < 5; i++) begin
      put(0, 8'd1);
      step();
    end
    chk("rct_nodrop", drp0, 16'd0);
    tca[0] = 1;
    step();
    chk("rct_clr", al0, 1'b0);
    for (int i = 0; i < 128; i++) begin
      put(0, (i % 2 == 0) ? 8'd0 : 8'd1);
      step();
    end
    chk("rct_refill", val0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
